// File: rtl/seq_pattern_checker.sv
// seq_pattern_checker: aligns a serial bit stream to a periodic N-bit pattern,
// declares lock after LOCK_CNT clean periods, counts bit errors while locked
// and drops lock after LOSS_CNT consecutive bad periods.
module seq_pattern_checker #(
    parameter int             N        = 6,
    parameter logic [N-1:0]   PATTERN  = 6'b110100,
    parameter int             LOCK_CNT = 2,
    parameter int             LOSS_CNT = 3,
    parameter int             CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             clr,
    output logic             locked,
    output logic             sync,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int FILL_W = $clog2(N + 1);
    localparam int PH_W   = $clog2(N);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(N - 1);
    localparam logic [3:0]        LOCK_TGT  = 4'(LOCK_CNT);
    localparam logic [3:0]        LOSS_TGT  = 4'(LOSS_CNT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state;
    logic [N-2:0]      sh;        // last N-1 sampled bits, newest in bit 0
    logic [FILL_W-1:0] fill;
    logic [PH_W-1:0]   phase;
    logic [3:0]        good;
    logic [3:0]        bad_run;
    logic              bad_flag;  // current LOCKED period has seen an error

    logic [N-1:0]      win;
    logic [FILL_W-1:0] fill_nxt;
    logic              exp_bit;
    logic              mism;
    logic              period_end;
    logic              counted_err;

    // Window, expected bit and per-sample event decode.
    always_comb begin
        win         = {sh, din};
        fill_nxt    = (fill == FILL_FULL) ? fill : fill + 1'b1;
        exp_bit     = PATTERN[PH_LAST - phase];
        mism        = (din != exp_bit);
        period_end  = (phase == PH_LAST);
        counted_err = en && (state == LOCKED) && mism;
    end

    // Alignment state machine with registered locked/sync/err outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            sh       <= '0;
            fill     <= '0;
            phase    <= '0;
            good     <= 4'd0;
            bad_run  <= 4'd0;
            bad_flag <= 1'b0;
            locked   <= 1'b0;
            sync     <= 1'b0;
            err      <= 1'b0;
        end else if (en) begin
            sh   <= win[N-2:0];
            fill <= fill_nxt;
            sync <= 1'b0;
            err  <= 1'b0;
            case (state)
                HUNT: begin
                    if ((fill_nxt == FILL_FULL) && (win == PATTERN)) begin
                        phase    <= '0;
                        good     <= 4'd1;
                        bad_run  <= 4'd0;
                        bad_flag <= 1'b0;
                        if (LOCK_CNT == 1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state  <= VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (mism) begin
                        state <= HUNT;
                        good  <= 4'd0;
                        phase <= '0;
                    end else if (period_end) begin
                        phase <= '0;
                        good  <= good + 4'd1;
                        if ((good + 4'd1) == LOCK_TGT) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            bad_run  <= 4'd0;
                            bad_flag <= 1'b0;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                LOCKED: begin
                    err <= mism;
                    if (period_end) begin
                        phase    <= '0;
                        sync     <= 1'b1;
                        bad_flag <= 1'b0;
                        if (bad_flag || mism) begin
                            if ((bad_run + 4'd1) == LOSS_TGT) begin
                                state   <= HUNT;
                                locked  <= 1'b0;
                                good    <= 4'd0;
                                bad_run <= 4'd0;
                            end else begin
                                bad_run <= bad_run + 4'd1;
                            end
                        end else begin
                            bad_run <= 4'd0;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                        if (mism) begin
                            bad_flag <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                    phase  <= '0;
                    good   <= 4'd0;
                end
            endcase
        end else begin
            sync <= 1'b0;
            err  <= 1'b0;
        end
    end

    // Saturating error counter; a clear keeps an error counted on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clr) begin
            err_cnt <= counted_err ? CNT_W'(1) : '0;
        end else if (counted_err && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
        end else begin
            err_cnt <= err_cnt;
        end
    end

endmodule

// File: tb/tb_seq_pattern_checker.sv
// Self-checking bench for seq_pattern_checker: directed scenarios with
// literal expectations plus a randomized stream, all checked every cycle
// against a queue-based behavioural model.
module tb_seq_pattern_checker;

    localparam int N        = 6;
    localparam int LOCK_CNT = 2;
    localparam int LOSS_CNT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic en  = 1'b0;
    logic clr = 1'b0;
    logic       locked, sync, err;
    logic [7:0] err_cnt;
    logic       locked2, sync2, err2;
    logic [1:0] err_cnt2;

    seq_pattern_checker #(.N(6), .PATTERN(6'b110100), .LOCK_CNT(2),
                          .LOSS_CNT(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .din(din), .en(en), .clr(clr),
        .locked(locked), .sync(sync), .err(err), .err_cnt(err_cnt));

    seq_pattern_checker #(.N(6), .PATTERN(6'b110100), .LOCK_CNT(2),
                          .LOSS_CNT(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .en(en), .clr(clr),
        .locked(locked2), .sync(sync2), .err(err2), .err_cnt(err_cnt2));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [5:0] pat_v = 6'b110100;
    int sp = 0;   // position in the transmitted pattern stream

    // behavioural model: mode 0 hunting, 1 verifying, 2 locked
    bit q[$];
    int m_mode, m_ph, m_good, m_badrun, m_cnt8, m_cnt2;
    bit m_badflag, m_locked, m_sync, m_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_mode = 0; m_ph = 0; m_good = 0; m_badrun = 0;
        m_cnt8 = 0; m_cnt2 = 0; m_badflag = 0;
        m_locked = 0; m_sync = 0; m_err = 0;
    endtask

    function automatic bit window_is_pattern();
        if (q.size() != N) return 1'b0;
        for (int i = 0; i < N; i++)
            if (q[i] != pat_v[N-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit b, input bit e, input bit c);
        bit hit;
        bit expb;
        hit = 0;
        m_sync = 0;
        m_err = 0;
        if (e) begin
            q.push_back(b);
            if (q.size() > N) void'(q.pop_front());
            expb = pat_v[N-1-m_ph];
            if (m_mode == 0) begin
                if (window_is_pattern()) begin
                    m_ph = 0; m_good = 1; m_badrun = 0; m_badflag = 0;
                    m_mode = (LOCK_CNT == 1) ? 2 : 1;
                end
            end else if (m_mode == 1) begin
                if (b != expb) begin
                    m_mode = 0; m_good = 0; m_ph = 0;
                end else if (m_ph == N-1) begin
                    m_ph = 0; m_good++;
                    if (m_good == LOCK_CNT) begin
                        m_mode = 2; m_badrun = 0; m_badflag = 0;
                    end
                end else begin
                    m_ph++;
                end
            end else begin
                if (b != expb) begin
                    m_err = 1; hit = 1; m_badflag = 1;
                end
                if (m_ph == N-1) begin
                    m_sync = 1; m_ph = 0;
                    if (m_badflag) begin
                        m_badrun++;
                        if (m_badrun == LOSS_CNT) begin
                            m_mode = 0; m_good = 0; m_badrun = 0;
                        end
                    end else begin
                        m_badrun = 0;
                    end
                    m_badflag = 0;
                end else begin
                    m_ph++;
                end
            end
            m_locked = (m_mode == 2);
        end
        if (c) begin
            m_cnt8 = hit; m_cnt2 = hit;
        end else if (hit) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    // drive one cycle: inputs change on the falling edge, model follows the rising edge
    task automatic drive(input bit b, input bit e, input bit c);
        @(negedge clk);
        din = b; en = e; clr = c;
        @(posedge clk);
        model_step(b, e, c);
        #1;
    endtask

    // send the next pattern bit of the stream, optionally inverted
    task automatic sb(input bit flip, input bit c = 1'b0);
        drive(pat_v[N-1-sp] ^ flip, 1'b1, c);
        sp = (sp + 1) % N;
    endtask

    task automatic do_reset();
        rst = 1'b1; din = 1'b0; en = 1'b0; clr = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sp = 0;
    endtask

    // per-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("locked", locked, m_locked);
            chk("sync", sync, m_sync);
            chk("err", err, m_err);
            chk("err_cnt", err_cnt, m_cnt8);
            chk("err_cnt_w2", err_cnt2, m_cnt2);
            chk("locked_w2", locked2, m_locked);
        end
    end

    initial begin
        do_reset();
        chk("reset_locked", locked, 0);
        chk("reset_sync", sync, 0);
        chk("reset_err", err, 0);
        chk("reset_cnt", err_cnt, 0);

        // 1: clean pattern, lock after bit 12, sync after bit 18
        for (int i = 1; i <= 18; i++) begin
            sb(1'b0);
            if (i == 11) chk("s1_not_locked_11", locked, 0);
            if (i == 12) chk("s1_locked_12", locked, 1);
            if (i == 17) chk("s1_nosync_17", sync, 0);
            if (i == 18) chk("s1_sync_18", sync, 1);
        end
        chk("s1_cnt", err_cnt, 0);

        // 2: one flipped bit (third of period)
        for (int i = 0; i < 6; i++) begin
            sb(i == 2);
            if (i == 2) chk("s2_err_pulse", err, 1);
            if (i == 3) chk("s2_err_once", err, 0);
        end
        chk("s2_cnt", err_cnt, 1);
        chk("s2_locked", locked, 1);
        for (int i = 0; i < 6; i++) sb(1'b0);

        // 3: three consecutive bad periods drop lock, then relock
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 6; i++) sb(i == 0);
        chk("s3_cnt", err_cnt, 4);
        chk("s3_unlocked", locked, 0);
        chk("s3_final_sync", sync, 1);
        for (int i = 1; i <= 12; i++) begin
            sb(1'b0);
            if (i == 11) chk("s3_not_relocked_11", locked, 0);
            if (i == 12) chk("s3_relocked_12", locked, 1);
        end

        // 4: mismatch during VERIFY returns to HUNT without counting
        do_reset();
        for (int i = 0; i < 6; i++) sb(1'b0);
        for (int i = 0; i < 6; i++) begin
            sb(i == 2);
            chk("s4_no_err", err, 0);
        end
        for (int i = 1; i <= 12; i++) begin
            sb(1'b0);
            if (i == 11) chk("s4_not_locked_11", locked, 0);
            if (i == 12) chk("s4_locked_12", locked, 1);
        end
        chk("s4_cnt", err_cnt, 0);

        // 5: enable toggling, lock counted in sampled bits
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            sb(1'b0);
            if (i == 11) chk("s5_not_locked_11", locked, 0);
            if (i == 12) chk("s5_locked_12", locked, 1);
            drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            chk("s5_idle_sync", sync, 0);
        end

        // 6a: clear on the same edge as a counted error
        for (int i = 0; i < 6; i++) sb(i == 1, i == 1);
        chk("s6_clr_cnt", err_cnt, 1);
        for (int i = 0; i < 6; i++) sb(1'b0);
        // 6b: five errors in one period saturate the 2-bit counter
        for (int i = 0; i < 6; i++) sb(i < 5);
        chk("s6_cnt8", err_cnt, 6);
        chk("s6_cnt2_sat", err_cnt2, 3);
        chk("s6_still_locked", locked, 1);
        // 6c: asynchronous reset mid-LOCKED takes effect before any edge
        rst = 1'b1;
        #1;
        chk("s6_rst_locked", locked, 0);
        chk("s6_rst_cnt", err_cnt, 0);
        chk("s6_rst_cnt2", err_cnt2, 0);
        do_reset();

        // randomized stream: enable gaps, bit flips, slips and clears
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) < 20) begin
                drive(1'($urandom_range(0, 1)), 1'b0, ($urandom_range(0, 99) < 3));
            end else begin
                if ($urandom_range(0, 299) == 0) sp = (sp + 1) % N;
                sb(($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 2));
            end
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
